// File: rtl/main_memory_pipelined_if.sv
`default_nettype none
// ============================================================================
// main_memory_pipelined_if : port A (fetch read) and port B (data r/w) bus
// Revision: 1.0
// ============================================================================
interface main_memory_pipelined_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  a_req;
  logic [31:0]           a_addr;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_err;

  logic                  b_req;
  logic                  b_we;
  logic [NBYTES-1:0]     b_be;
  logic [31:0]           b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_err;

  modport master (
    output a_req, a_addr, b_req, b_we, b_be, b_addr, b_wdata,
    input  a_rvalid, a_rdata, a_err, b_rvalid, b_rdata, b_err
  );

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_be, b_addr, b_wdata,
    output a_rvalid, a_rdata, a_err, b_rvalid, b_rdata, b_err
  );
endinterface
`default_nettype wire

// File: rtl/main_memory_pipelined.sv
`default_nettype none
// ============================================================================
// main_memory_pipelined : dual-port memory, fixed read latency, range checks
// Revision: 1.0
// ============================================================================
module main_memory_pipelined #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          DEPTH_WORDS    = 16384,
  parameter int          READ_LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          COLLISION_MODE = 0
) (
  input  wire logic               clk,
  input  wire logic               rst,
  main_memory_pipelined_if.slave  bus
);
  localparam int          NBYTES = DATA_WIDTH / 8;
  localparam int          OFF_W  = $clog2(NBYTES);
  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(NBYTES) * 33'(DEPTH_WORDS);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("main_memory_pipelined: READ_LATENCY must be in 1..4");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $error("main_memory_pipelined: DATA_WIDTH must be a power-of-two multiple of 8");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || OFF_W + IDX_W > 32) begin : g_bad_depth
    $error("main_memory_pipelined: DEPTH_WORDS must be a power of two fitting a 32-bit space");
  end
  if (COLLISION_MODE != 0 && COLLISION_MODE != 1) begin : g_bad_mode
    $error("main_memory_pipelined: COLLISION_MODE must be 0 or 1");
  end
  if (({1'b0, BASE_ADDR} % SPAN) != 33'd0) begin : g_bad_base
    $error("main_memory_pipelined: BASE_ADDR must be aligned to the memory span");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [31:0]      a_off, b_off;
  logic             a_in, b_in;
  logic [IDX_W-1:0] a_idx, b_idx;

  // addr >= BASE_ADDR excludes the wrap-around of the subtraction
  assign a_off = bus.a_addr - BASE_ADDR;
  assign b_off = bus.b_addr - BASE_ADDR;
  assign a_in  = (bus.a_addr >= BASE_ADDR) && ({1'b0, a_off} < SPAN);
  assign b_in  = (bus.b_addr >= BASE_ADDR) && ({1'b0, b_off} < SPAN);
  assign a_idx = a_off[OFF_W +: IDX_W];
  assign b_idx = b_off[OFF_W +: IDX_W];

  logic [DATA_WIDTH-1:0] a_word;

  if (COLLISION_MODE == 1) begin : g_write_first
    logic a_hit;
    assign a_hit = bus.b_req && bus.b_we && b_in && a_in && (a_idx == b_idx);
    always_comb begin
      a_word = mem[a_idx];
      for (int j = 0; j < NBYTES; j++) begin
        if (a_hit && bus.b_be[j]) begin
          a_word[j*8 +: 8] = bus.b_wdata[j*8 +: 8];
        end
      end
    end
  end else begin : g_read_first
    assign a_word = mem[a_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.b_req && bus.b_we && b_in) begin
      for (int j = 0; j < NBYTES; j++) begin
        if (bus.b_be[j]) begin
          mem[b_idx][j*8 +: 8] <= bus.b_wdata[j*8 +: 8];
        end
      end
    end
  end

  // Stage 0 captures the array read; later stages only delay it
  logic [READ_LATENCY-1:0] a_v, a_e, b_v, b_e;
  logic [DATA_WIDTH-1:0]   a_d [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   b_d [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      a_v <= '0;
      a_e <= '0;
      b_v <= '0;
      b_e <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        a_d[i] <= '0;
        b_d[i] <= '0;
      end
    end else begin
      a_v[0] <= bus.a_req;
      a_e[0] <= bus.a_req && !a_in;
      a_d[0] <= (bus.a_req && a_in) ? a_word : '0;
      b_v[0] <= bus.b_req;
      b_e[0] <= bus.b_req && !b_in;
      b_d[0] <= (bus.b_req && !bus.b_we && b_in) ? mem[b_idx] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        a_v[i] <= a_v[i-1];
        a_e[i] <= a_e[i-1];
        a_d[i] <= a_d[i-1];
        b_v[i] <= b_v[i-1];
        b_e[i] <= b_e[i-1];
        b_d[i] <= b_d[i-1];
      end
    end
  end

  assign bus.a_rvalid = a_v[READ_LATENCY-1];
  assign bus.a_err    = a_e[READ_LATENCY-1];
  assign bus.a_rdata  = a_d[READ_LATENCY-1];
  assign bus.b_rvalid = b_v[READ_LATENCY-1];
  assign bus.b_err    = b_e[READ_LATENCY-1];
  assign bus.b_rdata  = b_d[READ_LATENCY-1];
endmodule
`default_nettype wire

// File: tb/tb_main_memory_pipelined.sv
`default_nettype none
// ============================================================================
// tb_main_memory_pipelined : four DUTs (latency 1..4) driven by one vector table
// Revision: 1.0
// ============================================================================
module tb_main_memory_pipelined;
  localparam int NDUT = 4;
  localparam logic [3:0] NO  = 4'b0000;
  localparam logic [3:0] LO  = 4'b0111;
  localparam logic [3:0] HI  = 4'b1000;
  localparam logic [3:0] ALL = 4'b1111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req   = 1'b0;
  logic [31:0] a_addr  = '0;
  logic        b_req   = 1'b0;
  logic        b_we    = 1'b0;
  logic [3:0]  b_be    = '0;
  logic [31:0] b_addr  = '0;
  logic [31:0] b_wdata = '0;

  logic [NDUT-1:0]       a_rv, a_er, b_rv, b_er;
  logic [NDUT-1:0][31:0] a_rd, b_rd;

  // DUT k: READ_LATENCY k+1, COLLISION_MODE k%2; DUT 3 lives at 0x8000_0000 with 1024 words
  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam logic [31:0] BASE  = (k == 3) ? 32'h8000_0000 : 32'h0;
    localparam int          DEPTH = (k == 3) ? 1024 : 16384;
    main_memory_pipelined_if #(.DATA_WIDTH(32)) bus ();
    assign bus.a_req   = a_req;
    assign bus.a_addr  = a_addr;
    assign bus.b_req   = b_req;
    assign bus.b_we    = b_we;
    assign bus.b_be    = b_be;
    assign bus.b_addr  = b_addr;
    assign bus.b_wdata = b_wdata;
    assign a_rv[k] = bus.a_rvalid;
    assign a_rd[k] = bus.a_rdata;
    assign a_er[k] = bus.a_err;
    assign b_rv[k] = bus.b_rvalid;
    assign b_rd[k] = bus.b_rdata;
    assign b_er[k] = bus.b_err;
    main_memory_pipelined #(
      .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .READ_LATENCY(k + 1),
      .BASE_ADDR(BASE), .COLLISION_MODE(k % 2)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );
  end

  typedef struct {
    logic        rst;
    logic        a_req;
    logic [31:0] a_addr;
    logic        b_req;
    logic        b_we;
    logic [3:0]  b_be;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  amask;
    logic [31:0] ea0;
    logic [31:0] ea1;
    logic        eaerr;
    logic [3:0]  bmask;
    logic [31:0] eb;
    logic        eberr;
  } vec_t;

  vec_t v[$];

  logic [NDUT-1:0]       lav [64], lae [64], lbv [64], lbe [64];
  logic [NDUT-1:0][31:0] lad [64], lbd [64];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input int r, input int ar, input logic [31:0] aa,
                              input int br, input int bw, input logic [3:0] be,
                              input logic [31:0] ba, input logic [31:0] bd,
                              input logic [3:0] am, input logic [31:0] e0, input logic [31:0] e1,
                              input int ae, input logic [3:0] bm, input logic [31:0] eb,
                              input int bee);
    vec_t x;
    x.rst = (r != 0);   x.a_req = (ar != 0); x.a_addr = aa;
    x.b_req = (br != 0); x.b_we = (bw != 0); x.b_be = be; x.b_addr = ba; x.b_wdata = bd;
    x.amask = am; x.ea0 = e0; x.ea1 = e1; x.eaerr = (ae != 0);
    x.bmask = bm; x.eb = eb; x.eberr = (bee != 0);
    return x;
  endfunction

  task automatic chk(input string name, input int k, input int j,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d sample%0d actual=%h expected=%h", name, k, j, act, exp);
    end
  endtask

  initial begin
    int seen;
    logic [31:0] got;

    //         rst a  a_addr        b we be       b_addr        b_wdata       amask a0(mode0)     a1(mode1)     ae bmask eb            be
    v.push_back(mk(1, 1, 32'h0,        1, 1, 4'hF,   32'h300,      32'h5555_5555, NO, 0,            0,            0, NO,  0,            0));
    v.push_back(mk(1, 0, 32'h0,        0, 0, 4'h0,   32'h0,        32'h0,         NO, 0,            0,            0, NO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        0, 0, 4'h0,   32'h0,        32'h0,         NO, 0,            0,            0, NO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h100,      32'h1122_3344, NO, 0,            0,            0, LO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'b0101,32'h100,      32'hAABB_CCDD, NO, 0,            0,            0, LO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 0, 4'h0,   32'h100,      32'h0,         NO, 0,            0,            0, LO,  32'h11BB_33DD,0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h40,       32'hDEAD_BEEF, NO, 0,            0,            0, LO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 0, 4'h0,   32'h40,       32'h0,         NO, 0,            0,            0, LO,  32'hDEAD_BEEF,0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h200,      32'h0,         NO, 0,            0,            0, LO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h0,        32'hA0A0_A0A0, NO, 0,            0,            0, LO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h4,        32'hB1B1_B1B1, NO, 0,            0,            0, LO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h8,        32'hC2C2_C2C2, NO, 0,            0,            0, LO,  0,            0));
    v.push_back(mk(0, 1, 32'h200,      1, 1, 4'b1100,32'h200,      32'hFFFF_0000, LO, 32'h0,        32'hFFFF_0000,0, LO,  0,            0));
    v.push_back(mk(0, 1, 32'h200,      0, 0, 4'h0,   32'h0,        32'h0,         LO, 32'hFFFF_0000,32'hFFFF_0000,0, NO,  0,            0));
    v.push_back(mk(0, 1, 32'h0,        0, 0, 4'h0,   32'h0,        32'h0,         LO, 32'hA0A0_A0A0,32'hA0A0_A0A0,0, NO,  0,            0));
    v.push_back(mk(0, 1, 32'h4,        1, 1, 4'h0,   32'h40,       32'h1234_5678, LO, 32'hB1B1_B1B1,32'hB1B1_B1B1,0, LO,  0,            0));
    v.push_back(mk(0, 1, 32'h8,        0, 0, 4'h0,   32'h0,        32'h0,         LO, 32'hC2C2_C2C2,32'hC2C2_C2C2,0, NO,  0,            0));
    v.push_back(mk(0, 1, 32'h1_0000,   1, 0, 4'h0,   32'h40,       32'h0,         LO, 32'h0,        32'h0,        1, LO,  32'hDEAD_BEEF,0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'hFFFC,     32'h0F0F_0F0F, NO, 0,            0,            0, LO,  0,            0));
    v.push_back(mk(0, 1, 32'hFFFE,     0, 0, 4'h0,   32'h0,        32'h0,         LO, 32'h0F0F_0F0F,32'h0F0F_0F0F,0, NO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h300,      32'h1234_5678, NO, 0,            0,            0, LO,  0,            0));
    v.push_back(mk(0, 1, 32'h300,      0, 0, 4'h0,   32'h0,        32'h0,         LO, 32'h1234_5678,32'h1234_5678,0, NO,  0,            0));
    v.push_back(mk(1, 0, 32'h0,        1, 1, 4'hF,   32'h300,      32'hFFFF_FFFF, NO, 0,            0,            0, NO,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        0, 0, 4'h0,   32'h0,        32'h0,         NO, 0,            0,            0, NO,  0,            0));
    v.push_back(mk(0, 1, 32'h300,      1, 0, 4'h0,   32'h100,      32'h0,         LO, 32'h1234_5678,32'h1234_5678,0, LO,  32'h11BB_33DD,0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h8000_0000,32'hCAFE_F00D, NO, 0,            0,            0, HI,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h8000_0FFC,32'h0102_0304, NO, 0,            0,            0, HI,  0,            0));
    v.push_back(mk(0, 0, 32'h0,        1, 1, 4'hF,   32'h8000_1000,32'hBADB_AD00, NO, 0,            0,            0, ALL, 0,            1));
    v.push_back(mk(0, 1, 32'h7FFF_FFFC,1, 0, 4'h0,   32'h8000_0FFC,32'h0,         ALL,32'h0,        32'h0,        1, HI,  32'h0102_0304,0));
    v.push_back(mk(0, 1, 32'h8000_0000,1, 0, 4'h0,   32'h8000_0000,32'h0,         HI, 32'hCAFE_F00D,32'hCAFE_F00D,0, HI,  32'hCAFE_F00D,0));
    for (int i = 0; i < 5; i++)
      v.push_back(mk(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, NO, 0, 0, 0, NO, 0, 0));

    // Apply: vector i is accepted at edge i and the sample after that edge is log entry i
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      rst = v[i].rst; a_req = v[i].a_req; a_addr = v[i].a_addr;
      b_req = v[i].b_req; b_we = v[i].b_we; b_be = v[i].b_be;
      b_addr = v[i].b_addr; b_wdata = v[i].b_wdata;
      @(posedge clk);
      #1;
      lav[i] = a_rv; lad[i] = a_rd; lae[i] = a_er;
      lbv[i] = b_rv; lbd[i] = b_rd; lbe[i] = b_er;
    end

    for (int j = 0; j < v.size(); j++) begin
      for (int k = 0; k < NDUT; k++) begin
        int i;
        logic ev_a, ev_b;
        i = j - k;
        ev_a = 1'b0;
        ev_b = 1'b0;
        if (i >= 0) begin
          ev_a = v[i].a_req;
          ev_b = v[i].b_req;
          for (int t = i; t <= j; t++) begin
            if (v[t].rst) begin
              ev_a = 1'b0;
              ev_b = 1'b0;
            end
          end
        end
        chk("a_rvalid", k, j, 32'(lav[j][k]), 32'(ev_a));
        chk("b_rvalid", k, j, 32'(lbv[j][k]), 32'(ev_b));
        if (ev_a && v[i].amask[k]) begin
          chk("a_rdata", k, j, lad[j][k], (k % 2 == 1) ? v[i].ea1 : v[i].ea0);
          chk("a_err",   k, j, 32'(lae[j][k]), 32'(v[i].eaerr));
        end else if (!ev_a) begin
          chk("a_rdata_idle", k, j, lad[j][k], 32'h0);
          chk("a_err_idle",   k, j, 32'(lae[j][k]), 32'h0);
        end
        if (ev_b && v[i].bmask[k]) begin
          chk("b_rdata", k, j, lbd[j][k], v[i].eb);
          chk("b_err",   k, j, 32'(lbe[j][k]), 32'(v[i].eberr));
        end else if (!ev_b) begin
          chk("b_rdata_idle", k, j, lbd[j][k], 32'h0);
          chk("b_err_idle",   k, j, 32'(lbe[j][k]), 32'h0);
        end
      end
    end

    // Requests held through reset are ignored; the first one after release takes 4 cycles on DUT 3
    rst = 1'b1; a_req = 1'b1; a_addr = 32'h8000_0000; b_req = 1'b0; b_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("rst_quiet", 3, c, {24'h0, a_rv, b_rv}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = -1;
    got = '0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      a_req = 1'b0;
      if (a_rv[3] && seen < 0) begin
        seen = c;
        got = a_rd[3];
      end
    end
    chk("lat4_cycle", 3, 0, 32'(seen), 32'd3);
    chk("lat4_data",  3, 0, got, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
